// File: rtl/store_result_monitor_if.sv
// Observation bus between the core's data-memory write port
// and the store result monitor, plus the monitor's verdict outputs.
interface store_result_monitor_if;
  logic        en;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        pass;
  logic        fail;
  logic        done;
  logic [1:0]  fail_code;
  logic [15:0] store_cnt;
  logic [31:0] last_addr;
  logic [31:0] last_data;

  modport master (
    output en, memwrite, dataadr, writedata,
    input  pass, fail, done, fail_code,
    input  store_cnt, last_addr, last_data
  );

  modport slave (
    input  en, memwrite, dataadr, writedata,
    output pass, fail, done, fail_code,
    output store_cnt, last_addr, last_data
  );
endinterface

// File: rtl/store_result_monitor.sv
// Passive pass/fail monitor on the core's store port.
// Define STORE_MON_TIMEOUT_EN to build in the RUN-state timeout.
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic clk,
  input logic reset,
  store_result_monitor_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] laddr_q, laddr_d;
  logic [31:0] ldata_q, ldata_d;

  logic pass_hit, scr_hit, data_ok;
  logic pass_ok, pass_bad, verdict_st;
  logic tmo_hit;

  assign pass_hit   = bus.dataadr == PASS_ADDR;
  assign scr_hit    = bus.dataadr == SCRATCH_ADDR;
  assign data_ok    = bus.writedata == PASS_DATA;
  assign pass_ok    = pass_hit & data_ok;
  assign pass_bad   = pass_hit & ~data_ok;
  assign verdict_st = bus.memwrite & ~scr_hit;

`ifdef STORE_MON_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == S_RUN) &&
                   (tmo_q == TMAX);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_IDLE) tmo_d = '0;
    else if (state_q == S_RUN) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |32'(TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    laddr_d = laddr_q;
    ldata_d = ldata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.memwrite) begin
          if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
          laddr_d = bus.dataadr;
          ldata_d = bus.writedata;
          unique case (1'b1)
            pass_ok:  state_d = S_PASS;
            pass_bad: begin
              state_d = S_FAIL;
              code_d  = 2'd2;
            end
            scr_hit:  ;
            default: begin
              state_d = S_FAIL;
              code_d  = 2'd1;
            end
          endcase
        end
        // A deciding store in the last cycle beats the timeout
        if (tmo_hit && !verdict_st) begin
          state_d = S_FAIL;
          code_d  = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= 2'd0;
      cnt_q   <= 16'd0;
      laddr_q <= 32'd0;
      ldata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
    end
  end

  assign bus.pass      = state_q == S_PASS;
  assign bus.fail      = state_q == S_FAIL;
  assign bus.done      = state_q[1];
  assign bus.fail_code = code_q;
  assign bus.store_cnt = cnt_q;
  assign bus.last_addr = laddr_q;
  assign bus.last_data = ldata_q;

endmodule

// File: tb/tb_store_result_monitor.sv
// Directed bench for store_result_monitor: vector table
// plus async reset, timeout and saturation sequences.
module tb_store_result_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  store_result_monitor_if m ();

  store_result_monitor #(
    .PASS_ADDR    (32'd84),
    .PASS_DATA    (32'd7),
    .SCRATCH_ADDR (32'd80),
    .TIMEOUT      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  typedef struct {
    string       nm;
    bit          rst;
    logic        en;
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        p;
    logic        f;
    logic [1:0]  c;
    logic [15:0] n;
    logic [31:0] la;
    logic [31:0] ld;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    string nm, bit rst, logic en, logic mw,
    logic [31:0] a, logic [31:0] d,
    logic p, logic f, logic [1:0] c,
    logic [15:0] n, logic [31:0] la,
    logic [31:0] ld);
    vec_t v;
    v.nm = nm; v.rst = rst; v.en = en;
    v.mw = mw; v.a = a; v.d = d;
    v.p = p; v.f = f; v.c = c;
    v.n = n; v.la = la; v.ld = ld;
    return v;
  endfunction

  function automatic logic [84:0] obs();
    return {m.pass, m.fail, m.done,
            m.fail_code, m.store_cnt,
            m.last_addr, m.last_data};
  endfunction

  task automatic chk(string nm,
                     logic [84:0] exp);
    logic [84:0] got;
    got = obs();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic drive(logic en, logic mw,
                       logic [31:0] a,
                       logic [31:0] d);
    m.en = en;
    m.memwrite = mw;
    m.dataadr = a;
    m.writedata = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [84:0] ex(
    logic p, logic f, logic [1:0] c,
    logic [15:0] n, logic [31:0] la,
    logic [31:0] ld);
    return {p, f, p | f, c, n, la, ld};
  endfunction

  initial begin
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    // signature pass, en/store overlap in IDLE, en drop in RUN
    vq.push_back(mk("idle_st", 1, 0, 1, 80, 5,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("en_st", 0, 1, 1, 80, 9,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("scr", 0, 1, 1, 80, 5,
                    0, 0, 0, 1, 80, 5));
    vq.push_back(mk("sig_pass", 0, 0, 1, 84, 7,
                    1, 0, 0, 2, 84, 7));
    vq.push_back(mk("pass_hold", 0, 1, 1, 88, 1,
                    1, 0, 0, 2, 84, 7));
    // wrong data at pass address
    vq.push_back(mk("arm_b", 1, 1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("bad_dat", 0, 0, 1, 84, 'h5F3F,
                    0, 1, 2, 1, 84, 'h5F3F));
    vq.push_back(mk("fail_hold", 0, 1, 1, 84, 7,
                    0, 1, 2, 1, 84, 'h5F3F));
    // illegal address
    vq.push_back(mk("arm_c", 1, 1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("ill_adr", 0, 0, 1, 88, 7,
                    0, 1, 1, 1, 88, 7));
    // upper address bit must not alias
    vq.push_back(mk("arm_d", 1, 1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("hi_bit", 0, 0, 1,
                    32'h8000_0054, 7, 0, 1, 1, 1,
                    32'h8000_0054, 7));
    // back-to-back scratch stores
    vq.push_back(mk("arm_e", 1, 1, 0, 0, 0,
                    0, 0, 0, 0, 0, 0));
    vq.push_back(mk("b2b_1", 0, 0, 1, 80, 1,
                    0, 0, 0, 1, 80, 1));
    vq.push_back(mk("b2b_2", 0, 0, 1, 80, 2,
                    0, 0, 0, 2, 80, 2));
    vq.push_back(mk("b2b_3", 0, 0, 1, 80, 3,
                    0, 0, 0, 3, 80, 3));

    do_reset();
    chk("reset", ex(0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      drive(vq[i].en, vq[i].mw,
            vq[i].a, vq[i].d);
      @(negedge clk);
      chk(vq[i].nm, ex(vq[i].p, vq[i].f,
          vq[i].c, vq[i].n, vq[i].la,
          vq[i].ld));
    end

    // async reset between edges, mid-RUN
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1 chk("async_rst", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 84, 7);
    @(negedge clk);
    chk("idle_after", ex(0, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 84, 7);
    @(negedge clk);
    chk("rearm_pass", ex(1, 0, 0, 1, 84, 7));

`ifdef STORE_MON_TIMEOUT_EN
    begin
      int early;
      do_reset();
      drive(1'b1, 1'b0, 0, 0);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0);
      early = 0;
      repeat (15) begin
        @(negedge clk);
        if (m.done) early++;
      end
      n_chk++;
      if (early != 0) begin
        n_fail++;
        $display("FAIL tmo_early: got %0d want 0",
                 early);
      end
      @(negedge clk);
      chk("tmo_fire", ex(0, 1, 3, 0, 0, 0));

      do_reset();
      drive(1'b1, 1'b0, 0, 0);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0);
      repeat (15) @(negedge clk);
      drive(1'b0, 1'b1, 84, 7);
      @(negedge clk);
      chk("tmo_prio", ex(1, 0, 0, 1, 84, 7));
    end
`endif

    // saturation of store_cnt
    do_reset();
    drive(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 80, 32'hA5);
    repeat (65534) @(negedge clk);
    chk("cnt_65534",
        ex(0, 0, 0, 16'hFFFE, 80, 32'hA5));
    @(negedge clk);
    chk("cnt_65535",
        ex(0, 0, 0, 16'hFFFF, 80, 32'hA5));
    repeat (5) @(negedge clk);
    chk("cnt_sat",
        ex(0, 0, 0, 16'hFFFF, 80, 32'hA5));
    drive(1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
